// File: rtl/aes_ctr_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_ctr_stream_ctrl_if
// Bundles every non-clock signal of the AES-CTR stream controller.
//   slave  : the controller's view (configuration, data stream, core side)
//   master : the environment's view (config source, stream endpoints, AES core)
// Signal groups:
//   cfg_*      key/nonce/initial-counter load handshake
//   in_*       32-bit input word stream (valid/ready, last)
//   out_*      32-bit output word stream (valid/ready, last)
//   aes_*      start/key/block towards the core, ready/done/cipher back
//   ctr_wrap_o sticky counter-wrap flag
// ---------------------------------------------------------------------------
interface aes_ctr_stream_ctrl_if #(
  parameter int CTR_W = 32
);
  logic                 cfg_load_i;
  logic                 cfg_ready_o;
  logic [127:0]         key_i;
  logic [127-CTR_W:0]   nonce_i;
  logic [CTR_W-1:0]     ctr_init_i;

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [31:0]          in_data_i;
  logic                 in_last_i;

  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [31:0]          out_data_o;
  logic                 out_last_o;

  logic                 aes_start_o;
  logic [127:0]         aes_key_o;
  logic [127:0]         aes_block_o;
  logic                 aes_ready_i;
  logic                 aes_done_i;
  logic [127:0]         aes_cipher_i;

  logic                 ctr_wrap_o;

  modport slave (
    input  cfg_load_i, key_i, nonce_i, ctr_init_i,
    input  in_valid_i, in_data_i, in_last_i,
    input  out_ready_i,
    input  aes_ready_i, aes_done_i, aes_cipher_i,
    output cfg_ready_o, in_ready_o,
    output out_valid_o, out_data_o, out_last_o,
    output aes_start_o, aes_key_o, aes_block_o,
    output ctr_wrap_o
  );

  modport master (
    output cfg_load_i, key_i, nonce_i, ctr_init_i,
    output in_valid_i, in_data_i, in_last_i,
    output out_ready_i,
    output aes_ready_i, aes_done_i, aes_cipher_i,
    input  cfg_ready_o, in_ready_o,
    input  out_valid_o, out_data_o, out_last_o,
    input  aes_start_o, aes_key_o, aes_block_o,
    input  ctr_wrap_o
  );
endinterface

// File: rtl/aes_ctr_stream_ctrl.sv
// ---------------------------------------------------------------------------
// aes_ctr_stream_ctrl
// CTR-mode front end for an AES-128 block core. Builds counter blocks
// {nonce, ctr}, starts the core, captures the keystream block and XORs it
// word by word (MSW first) onto a 32-bit valid/ready stream.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - aes_ctr_stream_ctrl_if.slave: config load, input stream,
//          registered output stream, AES core handshake, sticky wrap flag
// ---------------------------------------------------------------------------
module aes_ctr_stream_ctrl #(
  parameter int CTR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_ctr_stream_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, STREAM} state_t;

  localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [127:0]        r_key;
  logic [127-CTR_W:0]  r_nonce;
  logic [CTR_W-1:0]    r_ctr;
  logic [127:0]        r_ks;
  logic [127:0]        r_aes_block;
  logic [1:0]          r_word_idx;
  logic                r_out_valid;
  logic [31:0]         r_out_data;
  logic                r_out_last;
  logic                r_ctr_wrap;

  logic [31:0]         w_ks_word [4];
  logic                w_cfg_ready;
  logic                w_cfg_fire;
  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_start;

  // Keystream split into 32-bit words, word 0 is the most significant.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ks_word
      assign w_ks_word[gi] = r_ks[127-32*gi -: 32];
    end
  endgenerate

  // Reloading is only safe between blocks: idle, or a fresh keystream with
  // no word consumed and nothing pending in the output register.
  assign w_cfg_ready = (r_state == IDLE) |
                       ((r_state == STREAM) & (r_word_idx == 2'd0) & !r_out_valid);
  assign w_cfg_fire  = bus.cfg_load_i & w_cfg_ready;

  // A reload in STREAM discards the keystream, so no word may be accepted
  // in the same cycle or it would be silently dropped.
  assign w_in_ready  = (r_state == STREAM) & !w_cfg_fire &
                       (!r_out_valid | bus.out_ready_i);
  assign w_in_fire   = bus.in_valid_i & w_in_ready;

  // Start is qualified by the core's ready in the same cycle, so it can
  // never be raised towards a busy core; leaving REQ makes it one cycle.
  assign w_start     = (r_state == REQ) & bus.aes_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_key       <= '0;
      r_nonce     <= '0;
      r_ctr       <= '0;
      r_ks        <= '0;
      r_aes_block <= '0;
      r_word_idx  <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_ctr_wrap  <= 1'b0;
    end else begin
      // Output register: loads on an input handshake, otherwise drains on
      // out_ready. Runs in every state so REQ/WAIT can drain the last word.
      if (w_in_fire) begin
        r_out_data  <= bus.in_data_i ^ w_ks_word[r_word_idx];
        r_out_last  <= bus.in_last_i;
        r_out_valid <= 1'b1;
      end else if (bus.out_ready_i) begin
        r_out_valid <= 1'b0;
      end

      if (w_cfg_fire) begin
        r_key       <= bus.key_i;
        r_nonce     <= bus.nonce_i;
        r_ctr       <= bus.ctr_init_i;
        r_ks        <= '0;
        r_word_idx  <= 2'd0;
        r_ctr_wrap  <= 1'b0;
        r_aes_block <= {bus.nonce_i, bus.ctr_init_i};
        r_state     <= REQ;
      end else begin
        case (r_state)
          REQ: begin
            if (w_start) begin
              r_state <= WAIT;
            end
          end
          WAIT: begin
            if (bus.aes_done_i) begin
              r_ks       <= bus.aes_cipher_i;
              r_ctr      <= r_ctr + CTR_ONE;
              r_word_idx <= 2'd0;
              if (&r_ctr) begin
                r_ctr_wrap <= 1'b1;
              end
              r_state    <= STREAM;
            end
          end
          STREAM: begin
            if (w_in_fire) begin
              r_word_idx <= r_word_idx + 2'd1;
              // End of block or end of message: prefetch the next block with
              // the already-incremented counter; leftover words are dropped.
              if ((r_word_idx == 2'd3) | bus.in_last_i) begin
                r_word_idx  <= 2'd0;
                r_aes_block <= {r_nonce, r_ctr};
                r_state     <= REQ;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.cfg_ready_o = w_cfg_ready;
  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.out_data_o  = r_out_data;
  assign bus.out_last_o  = r_out_last;
  assign bus.aes_start_o = w_start;
  assign bus.aes_key_o   = r_key;
  assign bus.aes_block_o = r_aes_block;
  assign bus.ctr_wrap_o  = r_ctr_wrap;

endmodule

// File: tb/tb_aes_ctr_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_ctr_stream_ctrl
// Directed bench for aes_ctr_stream_ctrl. The bench plays the AES core
// (ready/done/cipher) and both stream endpoints; all expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_aes_ctr_stream_ctrl;
  localparam int CTR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  aes_ctr_stream_ctrl_if #(.CTR_W(CTR_W)) bus ();

  aes_ctr_stream_ctrl #(.CTR_W(CTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [95:0]  FIPS_NONCE  = 96'h00112233445566778899aabb;
  localparam logic [127:0] FIPS_CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---- stimulus helpers (no checking inside) ------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus.cfg_load_i   = 1'b0;
    bus.key_i        = '0;
    bus.nonce_i      = '0;
    bus.ctr_init_i   = '0;
    bus.in_valid_i   = 1'b0;
    bus.in_data_i    = '0;
    bus.in_last_i    = 1'b0;
    bus.out_ready_i  = 1'b1;
    bus.aes_ready_i  = 1'b1;
    bus.aes_done_i   = 1'b0;
    bus.aes_cipher_i = '0;
  endtask

  task automatic do_cfg(input logic [127:0] k, input logic [95:0] n, input logic [31:0] c);
    bus.key_i      = k;
    bus.nonce_i    = n;
    bus.ctr_init_i = c;
    bus.cfg_load_i = 1'b1;
    tick();
    bus.cfg_load_i = 1'b0;
    #1;
  endtask

  task automatic wait_start(output bit seen, output logic [127:0] blk);
    seen = 1'b0;
    blk  = '0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus.aes_start_o === 1'b1) begin
        seen = 1'b1;
        blk  = bus.aes_block_o;
      end
      tick();
    end
    $display("core start seen=%0d block=%h", seen, blk);
  endtask

  task automatic give_done(input logic [127:0] c);
    bus.aes_cipher_i = c;
    bus.aes_done_i   = 1'b1;
    tick();
    bus.aes_done_i   = 1'b0;
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, output bit ok);
    bus.in_data_i  = d;
    bus.in_last_i  = last;
    bus.in_valid_i = 1'b1;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.in_ready_o === 1'b1) ok = 1'b1;
      tick();
    end
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
    #1;
    $display("word in=%h out=%h last=%b ok=%0d", d, bus.out_data_o, bus.out_last_o, ok);
  endtask

  // ---- tests ---------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (bus.cfg_ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_cfg_ready got=%b want=1", bus.cfg_ready_o);
    end
    total++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.out_last_o, bus.aes_start_o, bus.ctr_wrap_o} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000",
        {bus.in_ready_o, bus.out_valid_o, bus.out_last_o, bus.aes_start_o, bus.ctr_wrap_o});
    end
    total++;
    if ({bus.out_data_o, bus.aes_key_o, bus.aes_block_o} !== '0) begin
      bad++; $display("FAIL reset_buses data=%h key=%h block=%h want zeros",
        bus.out_data_o, bus.aes_key_o, bus.aes_block_o);
    end
    rst = 1'b0;
    tick();
    total++;
    if (bus.cfg_ready_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset cfg_ready=%b in_ready=%b want 1/0",
        bus.cfg_ready_o, bus.in_ready_o);
    end
  endtask

  task automatic test_fips();
    logic [31:0]  exp_w [4];
    logic [127:0] blk;
    bit seen, ok;
    exp_w = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    do_cfg(FIPS_KEY, FIPS_NONCE, 32'hccddeeff);
    wait_start(seen, blk);
    total++;
    if (!seen || blk !== 128'h00112233445566778899aabbccddeeff) begin
      bad++; $display("FAIL fips_block seen=%0d got=%h want=00112233445566778899aabbccddeeff", seen, blk);
    end
    total++;
    if (bus.aes_key_o !== FIPS_KEY) begin
      bad++; $display("FAIL fips_key got=%h want=%h", bus.aes_key_o, FIPS_KEY);
    end
    total++;
    if (bus.cfg_ready_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
      bad++; $display("FAIL fips_wait_ready cfg_ready=%b in_ready=%b want 0/0",
        bus.cfg_ready_o, bus.in_ready_o);
    end
    give_done(FIPS_CIPHER);
    total++;
    if (bus.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL fips_first_in_ready got=%b want=1", bus.in_ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      send_word(32'h0, (i == 3), ok);
      total++;
      if (!ok || bus.out_valid_o !== 1'b1 || bus.out_data_o !== exp_w[i] ||
          bus.out_last_o !== (i == 3)) begin
        bad++; $display("FAIL fips_word%0d ok=%0d valid=%b data=%h last=%b want data=%h last=%b",
          i, ok, bus.out_valid_o, bus.out_data_o, bus.out_last_o, exp_w[i], (i == 3));
      end
    end
    wait_start(seen, blk);
    total++;
    if (!seen || blk !== 128'h00112233445566778899aabbccddef00) begin
      bad++; $display("FAIL fips_prefetch seen=%0d got=%h want=...ccddef00", seen, blk);
    end
    give_done(128'h0);
  endtask

  task automatic test_multi_block();
    logic [31:0]  exp_w [6];
    logic [31:0]  pt [6];
    logic [127:0] blk;
    bit seen, ok;
    pt    = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'ha5a5a5a5, 32'h5a5a5a5a};
    exp_w = '{32'h963b1f27, 32'h9584fbcf, 32'h2732487f, 32'h8f4b3aa5, 32'ha486e0c2, 32'hd3f197b5};
    do_cfg(FIPS_KEY, FIPS_NONCE, 32'hccddeeff);
    wait_start(seen, blk);
    total++;
    if (!seen || blk[31:0] !== 32'hccddeeff) begin
      bad++; $display("FAIL multi_start1 seen=%0d ctr=%h want=ccddeeff", seen, blk[31:0]);
    end
    give_done(FIPS_CIPHER);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        wait_start(seen, blk);
        total++;
        if (!seen || blk !== 128'h00112233445566778899aabbccddef00) begin
          bad++; $display("FAIL multi_start2 seen=%0d got=%h want=...ccddef00", seen, blk);
        end
        give_done(128'h0123456789abcdeffedcba9876543210);
      end
      send_word(pt[i], (i == 5), ok);
      total++;
      if (!ok || bus.out_data_o !== exp_w[i] || bus.out_last_o !== (i == 5)) begin
        bad++; $display("FAIL multi_word%0d ok=%0d data=%h last=%b want data=%h last=%b",
          i, ok, bus.out_data_o, bus.out_last_o, exp_w[i], (i == 5));
      end
    end
    wait_start(seen, blk);
    total++;
    if (!seen || blk[31:0] !== 32'hccddef01) begin
      bad++; $display("FAIL multi_start3 seen=%0d ctr=%h want=ccddef01", seen, blk[31:0]);
    end
    give_done(128'h0);
  endtask

  task automatic test_backpressure();
    logic [127:0] blk;
    bit seen, ok;
    do_cfg(FIPS_KEY, FIPS_NONCE, 32'h00000010);
    wait_start(seen, blk);
    total++;
    if (!seen) begin
      bad++; $display("FAIL bp_start got=none want=pulse");
    end
    give_done(128'hdeadbeefcafebabe0123456789abcdef);
    send_word(32'h11111111, 1'b0, ok);
    total++;
    if (!ok || bus.out_data_o !== 32'hcfbcaffe) begin
      bad++; $display("FAIL bp_word0 ok=%0d data=%h want=cfbcaffe", ok, bus.out_data_o);
    end
    bus.out_ready_i = 1'b0;
    bus.in_data_i   = 32'h22222222;
    bus.in_valid_i  = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'hcfbcaffe) begin
        bad++; $display("FAIL bp_hold%0d in_ready=%b valid=%b data=%h want 0/1/cfbcaffe",
          i, bus.in_ready_o, bus.out_valid_o, bus.out_data_o);
      end
      tick();
    end
    bus.out_ready_i = 1'b1;
    #1;
    total++;
    if (bus.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL bp_release in_ready=%b want=1", bus.in_ready_o);
    end
    tick();
    bus.in_valid_i = 1'b0;
    #1;
    $display("word in=22222222 out=%h last=%b", bus.out_data_o, bus.out_last_o);
    total++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'he8dc989c) begin
      bad++; $display("FAIL bp_word1 valid=%b data=%h want=e8dc989c", bus.out_valid_o, bus.out_data_o);
    end
    send_word(32'h33333333, 1'b0, ok);
    total++;
    if (!ok || bus.out_data_o !== 32'h32107654) begin
      bad++; $display("FAIL bp_word2 ok=%0d data=%h want=32107654", ok, bus.out_data_o);
    end
    send_word(32'h44444444, 1'b1, ok);
    total++;
    if (!ok || bus.out_data_o !== 32'hcdef89ab || bus.out_last_o !== 1'b1) begin
      bad++; $display("FAIL bp_word3 ok=%0d data=%h last=%b want=cdef89ab/1",
        ok, bus.out_data_o, bus.out_last_o);
    end
    wait_start(seen, blk);
    give_done(128'h0);
  endtask

  task automatic test_wrap();
    logic [127:0] blk;
    bit seen, ok;
    do_cfg(FIPS_KEY, 96'ha5a5a5a5a5a5a5a5a5a5a5a5, 32'hffffffff);
    wait_start(seen, blk);
    total++;
    if (!seen || blk !== 128'ha5a5a5a5a5a5a5a5a5a5a5a5ffffffff || bus.ctr_wrap_o !== 1'b0) begin
      bad++; $display("FAIL wrap_first seen=%0d block=%h wrap=%b want ..ffffffff/0",
        seen, blk, bus.ctr_wrap_o);
    end
    give_done(128'h0f0e0d0c0b0a09080706050403020100);
    total++;
    if (bus.ctr_wrap_o !== 1'b1) begin
      bad++; $display("FAIL wrap_set got=%b want=1", bus.ctr_wrap_o);
    end
    send_word(32'h00000000, 1'b1, ok);
    total++;
    if (!ok || bus.out_data_o !== 32'h0f0e0d0c) begin
      bad++; $display("FAIL wrap_word ok=%0d data=%h want=0f0e0d0c", ok, bus.out_data_o);
    end
    wait_start(seen, blk);
    total++;
    if (!seen || blk !== 128'ha5a5a5a5a5a5a5a5a5a5a5a500000000 || bus.ctr_wrap_o !== 1'b1) begin
      bad++; $display("FAIL wrap_next seen=%0d block=%h wrap=%b want ..00000000/1",
        seen, blk, bus.ctr_wrap_o);
    end
    give_done(128'h0);
    total++;
    if (bus.cfg_ready_o !== 1'b1) begin
      bad++; $display("FAIL wrap_cfg_ready got=%b want=1", bus.cfg_ready_o);
    end
    do_cfg(FIPS_KEY, FIPS_NONCE, 32'h00000005);
    total++;
    if (bus.ctr_wrap_o !== 1'b0) begin
      bad++; $display("FAIL wrap_clear got=%b want=0", bus.ctr_wrap_o);
    end
    wait_start(seen, blk);
    give_done(128'h0);
  endtask

  task automatic test_core_busy();
    int starts;
    bus.aes_ready_i = 1'b0;
    do_cfg(128'hffeeddccbbaa99887766554433221100, FIPS_NONCE, 32'h00000042);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.aes_start_o !== 1'b0) starts++;
      tick();
    end
    total++;
    if (starts != 0) begin
      bad++; $display("FAIL busy_no_start got=%0d starts want=0", starts);
    end
    bus.aes_ready_i = 1'b1;
    #1;
    total++;
    if (bus.aes_start_o !== 1'b1 || bus.aes_block_o[31:0] !== 32'h00000042) begin
      bad++; $display("FAIL busy_start start=%b ctr=%h want 1/00000042",
        bus.aes_start_o, bus.aes_block_o[31:0]);
    end
    tick();
    total++;
    if (bus.aes_start_o !== 1'b0) begin
      bad++; $display("FAIL busy_single_pulse got=%b want=0", bus.aes_start_o);
    end
    bus.key_i      = 128'h11112222333344445555666677778888;
    bus.cfg_load_i = 1'b1;
    #1;
    total++;
    if (bus.cfg_ready_o !== 1'b0) begin
      bad++; $display("FAIL busy_cfg_ready got=%b want=0", bus.cfg_ready_o);
    end
    tick();
    bus.cfg_load_i = 1'b0;
    #1;
    total++;
    if (bus.aes_key_o !== 128'hffeeddccbbaa99887766554433221100 || bus.aes_start_o !== 1'b0) begin
      bad++; $display("FAIL busy_cfg_ignored key=%h start=%b want ffeeddcc..1100/0",
        bus.aes_key_o, bus.aes_start_o);
    end
    give_done(128'h0);
    total++;
    if (bus.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL busy_stream in_ready=%b want=1", bus.in_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] blk;
    bit seen;
    do_cfg(FIPS_KEY, FIPS_NONCE, 32'hffffffff);
    wait_start(seen, blk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.cfg_ready_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b0 ||
        bus.aes_start_o !== 1'b0 || bus.ctr_wrap_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_flags cfg=%b in=%b ov=%b st=%b wr=%b want 1/0/0/0/0",
        bus.cfg_ready_o, bus.in_ready_o, bus.out_valid_o, bus.aes_start_o, bus.ctr_wrap_o);
    end
    total++;
    if (bus.out_data_o !== 32'h0 || bus.aes_key_o !== 128'h0 || bus.aes_block_o !== 128'h0) begin
      bad++; $display("FAIL rstmid_buses data=%h key=%h block=%h want zeros",
        bus.out_data_o, bus.aes_key_o, bus.aes_block_o);
    end
    tick();
    rst = 1'b0;
    give_done(FIPS_CIPHER);
    total++;
    if (bus.in_ready_o !== 1'b0 || bus.cfg_ready_o !== 1'b1 || bus.ctr_wrap_o !== 1'b0 ||
        bus.aes_key_o !== 128'h0) begin
      bad++; $display("FAIL rstmid_late_done in=%b cfg=%b wrap=%b key=%h want 0/1/0/0",
        bus.in_ready_o, bus.cfg_ready_o, bus.ctr_wrap_o, bus.aes_key_o);
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_fips();
    test_multi_block();
    test_backpressure();
    test_wrap();
    test_core_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
